// File: rtl/shifter_pkg.sv
// Shared definitions for the pipelined barrel shifter.
// Optional feature macro: ROTATE_EN (enables ROL/ROR).
package shifter_pkg;

    localparam logic [2:0] OP_SLL = 3'b000;
    localparam logic [2:0] OP_SRL = 3'b001;
    localparam logic [2:0] OP_SRA = 3'b011;
    localparam logic [2:0] OP_ROL = 3'b100;
    localparam logic [2:0] OP_ROR = 3'b101;

    // Pipeline stage that computes shift layer i (shift by 2**i).
    function automatic int unsigned stage_of_layer(input int unsigned i,
                                                   input int unsigned shamt_w,
                                                   input int unsigned pipe_stages);
        return (i * pipe_stages) / shamt_w;
    endfunction

    // Lowest layer owned by stage k; k == pipe_stages yields shamt_w so that
    // first_layer(k+1)-1 is always the last layer of stage k.
    function automatic int unsigned first_layer(input int unsigned k,
                                                 input int unsigned shamt_w,
                                                 input int unsigned pipe_stages);
        int unsigned first;
        first = shamt_w;
        for (int unsigned i = shamt_w; i > 0; i--) begin
            if (stage_of_layer(i - 1, shamt_w, pipe_stages) >= k) begin
                first = i - 1;
            end
        end
        return first;
    endfunction

    // Ops with a defined result; everything else produces zero.
    function automatic logic op_supported(input logic [2:0] op);
        logic ok;
        ok = (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
`ifdef ROTATE_EN
        ok = ok || (op == OP_ROL) || (op == OP_ROR);
`endif
        return ok;
    endfunction

endpackage

// File: rtl/shift_stage.sv
// One pipeline stage of the barrel shifter: layers FIRST..LAST followed by a
// register with stall hold and valid squash.
// Optional feature macro: ROTATE_EN (rotate wrap logic).
module shift_stage
    import shifter_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned SHAMT_W = 5,
    parameter int unsigned TAG_W   = 5,
    parameter int unsigned FIRST   = 0,
    parameter int unsigned LAST    = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               advance,
    input  logic               in_valid,
    input  logic [2:0]         in_op,
    input  logic [XLEN-1:0]    in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic               in_fill,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    output logic [2:0]         out_op,
    output logic [XLEN-1:0]    out_data,
    output logic [SHAMT_W-1:0] out_shamt,
    output logic               out_fill,
    output logic [TAG_W-1:0]   out_tag
);

    // Single layer: shift by n, SRA fills with the sign captured at stage 0.
    function automatic logic [XLEN-1:0] layer(input logic [XLEN-1:0] d,
                                              input logic [2:0]      op,
                                              input logic            fill,
                                              input int unsigned     n);
        logic [XLEN-1:0] ones;
        logic [XLEN-1:0] r;
        ones = '1;
        case (op)
            OP_SLL:  r = d << n;
            OP_SRL:  r = d >> n;
            OP_SRA:  r = (d >> n) | (fill ? ~(ones >> n) : '0);
`ifdef ROTATE_EN
            OP_ROL:  r = (d << n) | (d >> (XLEN - n));
            OP_ROR:  r = (d >> n) | (d << (XLEN - n));
`endif
            default: r = '0;
        endcase
        return r;
    endfunction

    logic [XLEN-1:0] chain [FIRST:LAST+1];

    assign chain[FIRST] = in_data;

    for (genvar g = FIRST; g <= LAST; g++) begin : g_layer
        assign chain[g+1] = in_shamt[g] ? layer(chain[g], in_op, in_fill, 1 << g)
                                        : chain[g];
    end

    // Stage register: squash on reset/flush, freeze while the pipe is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_op    <= '0;
            out_data  <= '0;
            out_shamt <= '0;
            out_fill  <= 1'b0;
            out_tag   <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (advance) begin
            out_valid <= in_valid;
            out_op    <= in_op;
            out_data  <= chain[LAST+1];
            out_shamt <= in_shamt;
            out_fill  <= in_fill;
            out_tag   <= in_tag;
        end
    end

endmodule

// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter (SLL/SRL/SRA, optional ROL/ROR) with valid/ready
// on both sides, a pass-through tag and synchronous flush.
// Optional feature macro: ROTATE_EN (ops 100/101 are reserved without it).
module pipelined_shifter
    import shifter_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned SHAMT_W     = $clog2(XLEN),
    parameter int unsigned PIPE_STAGES = 2,
    parameter int unsigned TAG_W       = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         in_op,
    input  logic [XLEN-1:0]    in_a,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    out_r,
    output logic [TAG_W-1:0]   out_tag
);

    logic               advance;
    logic               op_ok;

    // Index 0 is the stage-0 input; index k+1 is the register of stage k.
    logic               v_c  [PIPE_STAGES+1];
    logic [2:0]         op_c [PIPE_STAGES+1];
    logic [XLEN-1:0]    d_c  [PIPE_STAGES+1];
    logic [SHAMT_W-1:0] sh_c [PIPE_STAGES+1];
    logic               f_c  [PIPE_STAGES+1];
    logic [TAG_W-1:0]   t_c  [PIPE_STAGES+1];

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance && !flush;

    // Reserved ops enter as zero data with zero fill, so every layer keeps them zero.
    always_comb begin
        op_ok   = op_supported(in_op);
        v_c[0]  = in_valid && in_ready;
        op_c[0] = in_op;
        d_c[0]  = op_ok ? in_a : '0;
        sh_c[0] = in_shamt;
        f_c[0]  = op_ok && in_a[XLEN-1];
        t_c[0]  = in_tag;
    end

    for (genvar k = 0; k < PIPE_STAGES; k++) begin : g_stage
        shift_stage #(
            .XLEN    (XLEN),
            .SHAMT_W (SHAMT_W),
            .TAG_W   (TAG_W),
            .FIRST   (first_layer(k, SHAMT_W, PIPE_STAGES)),
            .LAST    (first_layer(k + 1, SHAMT_W, PIPE_STAGES) - 1)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .flush     (flush),
            .advance   (advance),
            .in_valid  (v_c[k]),
            .in_op     (op_c[k]),
            .in_data   (d_c[k]),
            .in_shamt  (sh_c[k]),
            .in_fill   (f_c[k]),
            .in_tag    (t_c[k]),
            .out_valid (v_c[k+1]),
            .out_op    (op_c[k+1]),
            .out_data  (d_c[k+1]),
            .out_shamt (sh_c[k+1]),
            .out_fill  (f_c[k+1]),
            .out_tag   (t_c[k+1])
        );
    end

    assign out_valid = v_c[PIPE_STAGES];
    assign out_r     = d_c[PIPE_STAGES];
    assign out_tag   = t_c[PIPE_STAGES];

    // Control fields are spent once the last layer has been applied.
    logic unused_tail;
    assign unused_tail = ^{op_c[PIPE_STAGES], sh_c[PIPE_STAGES], f_c[PIPE_STAGES]};

endmodule

// File: tb/tb_pipelined_shifter.sv
// Randomized self-checking bench for pipelined_shifter: a 32-bit/2-stage
// instance under random handshake, flush and reset, plus a 64-bit/3-stage
// instance exercised one op at a time.
module tb_pipelined_shifter;

    localparam int unsigned XLEN = 32;
    localparam int unsigned P    = 2;

    localparam logic [2:0] SLL = 3'b000;
    localparam logic [2:0] SRL = 3'b001;
    localparam logic [2:0] SRA = 3'b011;
    localparam logic [2:0] ROR = 3'b101;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 32-bit, 2-stage instance
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [2:0]  in_op;
    logic [31:0] in_a, out_r;
    logic [4:0]  in_shamt, in_tag, out_tag;

    // 64-bit, 3-stage instance
    logic        b_rst, b_in_valid, b_in_ready, b_out_valid;
    logic [2:0]  b_in_op;
    logic [63:0] b_in_a, b_out_r;
    logic [5:0]  b_in_shamt;
    logic [4:0]  b_in_tag, b_out_tag;

    pipelined_shifter #(.XLEN(32), .PIPE_STAGES(2), .TAG_W(5)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a),
        .in_shamt(in_shamt), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r), .out_tag(out_tag)
    );

    pipelined_shifter #(.XLEN(64), .PIPE_STAGES(3), .TAG_W(5)) dut64 (
        .clk(clk), .rst(b_rst), .flush(1'b0),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_op(b_in_op), .in_a(b_in_a),
        .in_shamt(b_in_shamt), .in_tag(b_in_tag),
        .out_valid(b_out_valid), .out_ready(1'b1), .out_r(b_out_r), .out_tag(b_out_tag)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference: shift semantics on a w-bit value using whole-word arithmetic.
    function automatic logic [63:0] ref_shift(input logic [2:0] op, input logic [63:0] a_in,
                                              input int unsigned sh, input int unsigned w);
        logic [63:0] mask, a, sx, r;
        mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        a  = a_in & mask;
        sx = a[w-1] ? (a | ~mask) : a;
        case (op)
            SLL:    r = a << sh;
            SRL:    r = a >> sh;
            SRA:    r = 64'($signed(sx) >>> sh);
`ifdef ROTATE_EN
            3'b100: r = (sh == 0) ? a : ((a << sh) | (a >> (w - sh)));
            ROR:    r = (sh == 0) ? a : ((a >> sh) | (a << (w - sh)));
`endif
            default: r = 64'd0;
        endcase
        return r & mask;
    endfunction

    // Scoreboard for the 32-bit instance
    logic [31:0] q_r[$];
    logic [4:0]  q_tag[$];
    int unsigned q_adv[$];
    int unsigned adv_total = 0;
    logic        hold_pend = 1'b0, prev_clear = 1'b0, must_hold = 1'b0;
    logic [31:0] hold_r;
    logic [4:0]  hold_tag;

    // One clock cycle: observe at the falling edge, update the model, return #1 after rise.
    task automatic step();
        logic        adv;
        logic [63:0] e;
        @(negedge clk);
        adv = !out_valid || out_ready;
        if (prev_clear) check_val("valid_after_clear", 64'(out_valid), 64'(0));
        check_val("in_ready", 64'(in_ready), 64'(adv && !flush));
        if (hold_pend) begin
            check_val("stall_valid", 64'(out_valid), 64'(1));
            check_val("stall_r", 64'(out_r), 64'(hold_r));
            check_val("stall_tag", 64'(out_tag), 64'(hold_tag));
        end
        if (out_valid && out_ready) begin
            if (q_r.size() == 0) begin
                check_val("spurious_out", 64'(out_valid), 64'(0));
            end else begin
                check_val("out_r", 64'(out_r), 64'(q_r.pop_front()));
                check_val("out_tag", 64'(out_tag), 64'(q_tag.pop_front()));
                check_val("latency", 64'(adv_total - q_adv.pop_front()), 64'(P));
            end
        end
        if (in_valid && in_ready) begin
            e = ref_shift(in_op, 64'(in_a), int'(in_shamt), XLEN);
            q_r.push_back(e[31:0]);
            q_tag.push_back(in_tag);
            q_adv.push_back(adv_total);
        end
        if (adv) adv_total++;
        hold_pend  = out_valid && !out_ready && !flush && !rst;
        hold_r     = out_r;
        hold_tag   = out_tag;
        prev_clear = flush || rst;
        must_hold  = in_valid && !in_ready;
        if (flush || rst) begin
            q_r.delete();
            q_tag.delete();
            q_adv.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [4:0] sh,
                         input logic [4:0] tag);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_shamt = sh;
        in_tag   = tag;
    endtask

    // One op through the 64-bit instance, checking value, tag and latency.
    task automatic run64(input logic [2:0] op, input logic [63:0] a, input int unsigned sh,
                         input logic [4:0] tag);
        logic [63:0] e;
        int unsigned lat;
        e          = ref_shift(op, a, sh, 64);
        b_in_valid = 1'b1;
        b_in_op    = op;
        b_in_a     = a;
        b_in_shamt = 6'(sh);
        b_in_tag   = tag;
        @(negedge clk);
        check_val("b_in_ready", 64'(b_in_ready), 64'(1));
        @(posedge clk);
        #1;
        b_in_valid = 1'b0;
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (b_out_valid) begin
                lat = i;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (lat == 0) begin
            check_val("b_timeout", 64'(b_out_valid), 64'(1));
        end else begin
            check_val("b_out_r", b_out_r, e);
            check_val("b_out_tag", 64'(b_out_tag), 64'(tag));
            check_val("b_latency", 64'(lat), 64'(3));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_op = '0; in_a = '0; in_shamt = '0; in_tag = '0;
        b_rst = 1'b1; b_in_valid = 1'b0; b_in_op = '0; b_in_a = '0; b_in_shamt = '0; b_in_tag = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_val("rst_out_valid", 64'(out_valid), 64'(0));
        check_val("rst_out_r", 64'(out_r), 64'(0));
        check_val("rst_out_tag", 64'(out_tag), 64'(0));
        check_val("rst_in_ready", 64'(in_ready), 64'(1));

        // SRA sign fill with exact two-cycle latency and a one-cycle valid pulse
        drive(SRA, 32'h8000_0000, 5'd4, 5'd7);
        step();
        in_valid = 1'b0;
        step();
        check_val("sra_valid", 64'(out_valid), 64'(1));
        check_val("sra_r", 64'(out_r), 64'h0000_0000_F800_0000);
        check_val("sra_tag", 64'(out_tag), 64'(7));
        step();
        check_val("sra_pulse", 64'(out_valid), 64'(0));

        // Back-to-back shifts by the maximum amount
        drive(SLL, 32'h0000_0001, 5'd31, 5'd1); step();
        drive(SRL, 32'h8000_0000, 5'd31, 5'd2); step();
        drive(SRA, 32'h8000_0000, 5'd31, 5'd3); step();
        in_valid = 1'b0;
        repeat (4) step();

        // Backpressure: result held while the consumer stalls, a third op waits upstream
        out_ready = 1'b0;
        drive(SLL, 32'h1234_5678, 5'd4, 5'd10); step();
        drive(SRL, 32'h1234_5678, 5'd8, 5'd11); step();
        drive(SRA, 32'hF000_000F, 5'd0, 5'd12);
        repeat (4) step();
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (!must_hold) in_valid = 1'b0;
            step();
        end

        // Flush with two ops in flight, then a fresh op
        drive(SLL, 32'hDEAD_BEEF, 5'd3, 5'd20); step();
        drive(SRL, 32'hDEAD_BEEF, 5'd3, 5'd21); step();
        flush = 1'b1;
        drive(SRA, 32'h8765_4321, 5'd5, 5'd22); step();
        flush = 1'b0;
        in_valid = 1'b0; step();
        drive(SRL, 32'hCAFE_F00D, 5'd12, 5'd23); step();
        in_valid = 1'b0;
        repeat (4) step();

        // Reset with two ops in flight
        drive(SLL, 32'h0F0F_0F0F, 5'd1, 5'd24); step();
        drive(SRL, 32'h0F0F_0F0F, 5'd1, 5'd25); step();
        in_valid = 1'b0;
        rst = 1'b1; step();
        rst = 1'b0;
        repeat (4) step();

        // Random traffic including reserved ops, stalls, flushes and resets
        for (int n = 0; n < 3000; n++) begin
            if (!must_hold) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_op    = 3'($urandom_range(0, 7));
                case ($urandom_range(0, 3))
                    0:       in_a = 32'h8000_0000;
                    1:       in_a = 32'h0000_0001;
                    default: in_a = $urandom;
                endcase
                in_shamt = 5'($urandom_range(0, 31));
                in_tag   = 5'($urandom_range(0, 31));
            end
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            rst       = ($urandom_range(0, 199) == 0);
            step();
        end
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (6) step();
        check_val("drain_empty", 64'(q_r.size()), 64'(0));

        // 64-bit, 3-stage instance
        b_rst = 1'b0;
        check_val("b_rst_valid", 64'(b_out_valid), 64'(0));
        run64(ROR, 64'h0000_0000_0000_0001, 1, 5'd9);
        run64(SRA, 64'h8000_0000_0000_0000, 63, 5'd10);
        for (int n = 0; n < 30; n++) begin
            run64(3'($urandom_range(0, 7)), {$urandom, $urandom}, $urandom_range(0, 63),
                  5'($urandom_range(0, 31)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
